// File: rtl/sm_mdu.sv
// HI/LO multiply/divide sequencer: MULT/MULTU by shift-add, DIV/DIVU by restoring division,
// one iteration per clock, with sign fix-up applied in a final FIX cycle.
module sm_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [1:0]         op_q;
  logic               neg_a_q, neg_b_q, dz_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand for multiply, divisor for divide
  logic [2*WIDTH-1:0] prod_q;   // divide uses the low half as dividend/quotient shifter
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial, div_diff, rem_next;
  logic               div_ok;
  logic [WIDTH-1:0]   quo_next;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quo, fix_rem;

  always_comb begin
    a_neg = op[0] & srcA[WIDTH-1];
    b_neg = op[0] & srcB[WIDTH-1];
    a_mag = a_neg ? -srcA : srcA;
    b_mag = b_neg ? -srcB : srcB;

    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    div_trial = {rem_q[WIDTH-1:0], prod_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    div_ok    = ~div_diff[WIDTH];
    rem_next  = div_ok ? div_diff : div_trial;
    quo_next  = {prod_q[WIDTH-2:0], div_ok};

    fix_prod = (op_q == 2'b01 && (neg_a_q ^ neg_b_q)) ? -prod_q : prod_q;
    fix_quo  = (op_q[0] && (neg_a_q ^ neg_b_q)) ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    fix_rem  = (op_q[0] && neg_a_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      a_raw_q <= '0;
      opnd_q  <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q    <= op;
            neg_a_q <= a_neg;
            neg_b_q <= b_neg;
            dz_q    <= op[1] && (srcB == '0);
            a_raw_q <= srcA;
            opnd_q  <= op[1] ? b_mag : a_mag;
            prod_q  <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            rem_q   <= '0;
            cnt_q   <= CntW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (op_q[1]) begin
            rem_q              <= rem_next;
            prod_q[WIDTH-1:0]  <= quo_next;
          end else begin
            prod_q <= mul_next;
          end
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          if (!op_q[1]) begin
            hi_q <= fix_prod[2*WIDTH-1:WIDTH];
            lo_q <= fix_prod[WIDTH-1:0];
          end else if (dz_q) begin
            hi_q <= a_raw_q;
            lo_q <= '1;
          end else begin
            hi_q <= fix_rem;
            lo_q <= fix_quo;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/sm_mdu.md
# sm_mdu

Multi-cycle multiply/divide sequencer for the schoolMIPS core. It owns the HI/LO register pair and executes MULT, MULTU, DIV and DIVU with one shift-add or restoring-subtract step per clock. It reports `busy` so the core's control can stall MFHI/MFLO until the result is ready. It sits beside the single-cycle ALU: the core's control decodes the instruction and drives `start`/`op`, and the register file operands feed `srcA`/`srcB`.

## Interface
Parameters:
- `WIDTH`, default 32: operand, HI and LO width. Iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  launch the operation in `op`; sampled only in IDLE or DONE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `srcA`  in  WIDTH  multiplicand / dividend (rs).
- `srcB`  in  WIDTH  multiplier / divisor (rt).
- `hi_we`  in  1  MTHI: write `wdata` to HI.
- `lo_we`  in  1  MTLO: write `wdata` to LO.
- `wdata`  in  WIDTH  MTHI/MTLO data (rs).
- `busy`  out  1  operation in progress; HI/LO not valid.
- `done`  out  1  one-cycle pulse: HI/LO just updated.
- `hi`  out  WIDTH  HI register (MFHI source).
- `lo`  out  WIDTH  LO register (MFLO source).

## Operation
- States: IDLE, RUN, FIX, DONE. Reset forces IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, iteration counter=0.
- IDLE/DONE + `start`: latch the operand magnitudes. For signed ops, negate negative operands to their absolute value and record sign flags. Load counter=WIDTH-1 and go to RUN. DONE without `start` → IDLE.
- RUN, multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first, over a WIDTH+1-bit partial remainder.
- RUN: counter decrements each cycle; when counter==0 go to FIX.
- FIX: apply signs, write HI/LO, go to DONE.
  - MULT: negate the 2·WIDTH product if the operand signs differ. HI=upper half, LO=lower half.
  - MULTU: HI/LO = unsigned product.
  - DIV/DIVU: LO=quotient, HI=remainder. For DIV, negate the quotient if the signs differ; the remainder takes the dividend's sign.
- Divide by zero (`srcB`==0 at start, DIV or DIVU): full latency still applies. Result is fixed: LO=all ones, HI=`srcA` as latched (original signed value, not magnitude).
- DIV overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude datapath with WIDTH-bit wraparound.
- `start` in RUN or FIX: ignored, with no queueing. Control must not issue a second MULT/DIV while `busy`.
- `hi_we`/`lo_we` in IDLE or DONE: register write at the clock edge.
- `hi_we`/`lo_we` in RUN or FIX: ignored.
- `start` together with `hi_we`/`lo_we` in the same cycle: the write takes effect, then is overwritten by FIX.
- MFHI/MFLO issued while `busy`=1: control must stall the PC. `hi`/`lo` hold their pre-operation values until FIX.
- `rst` asserted in any state: the operation is aborted and every register returns to its reset value on that edge.

## Timing
- E0 = the edge that samples `start`.
- `busy`=1 in the cycles after edges E0 through E32: WIDTH+1 = 33 cycles.
- RUN iterations occur on edges E1..E32. FIX writes HI/LO on edge E33.
- After E33: `done`=1 for exactly one cycle, `busy`=0, new `hi`/`lo` visible.
- MFHI issued in the cycle after E33 reads the new result.
- Back-to-back: `start` in the DONE cycle is accepted, giving a throughput of one operation per WIDTH+2 cycles.
- `busy`, `done`, `hi` and `lo` are direct register outputs; there is no combinational path from inputs to outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles, `done` pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7 / 2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 100 / 7 → LO=14, HI=2. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIVU 5 / 0 → after full latency, LO=0xFFFFFFFF, HI=5.
- MTHI 0x1234 in IDLE → `hi`=0x1234 next cycle. Then start MULTU 2×3 and pulse `lo_we` and a second `start` mid-RUN → both ignored, `hi` holds 0x1234 until FIX; final HI=0, LO=6.
- Start DIVU and assert `rst` at RUN cycle 10 → next cycle IDLE, `busy`=0, `hi`=`lo`=0, no `done`. A fresh MULTU 4×5 then completes normally: LO=20.
